// File: rtl/fp_pkg.sv
// Shared FP16/FP12 field constants, special encodings and the result flag bundle
// for the narrowing converter.
package fp_pkg;

  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;
  localparam int unsigned FP12_EXP_W = 5;
  localparam int unsigned FP12_MAN_W = 6;
  localparam int unsigned FP_BIAS    = 15;

  // Mantissa bits dropped when going from FP16 to FP12
  localparam int unsigned DROP_W = FP16_MAN_W - FP12_MAN_W;

  localparam logic [FP12_EXP_W-1:0] EXP_MAX      = 5'h1F;
  localparam logic [11:0]           FP12_QNAN    = 12'h7E0;
  localparam logic [10:0]           FP12_MAX_FIN = 11'h7BF;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  typedef struct packed {
    logic nan;
    logic overflow;
    logic inexact;
  } fp_flags_t;

endpackage

// File: rtl/fp16_to_fp12_narrow_if.sv
// Valid/ready stream bundle for the converter: FP16 words in, FP12 results and flags out.
interface fp16_to_fp12_narrow_if;
  import fp_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  fp_flags_t   out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/fp_sat_counter.sv
// Event counter that sticks at all-ones; clear wins over a same-cycle increment.
module fp_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fp16_to_fp12_narrow.sv
// Two-stage FP16 -> FP12 narrowing converter with RNE rounding, flags and event counters.
// Define FP16_TO_FP12_STOCHASTIC_EN to replace RNE with LFSR-driven stochastic rounding.
module fp16_to_fp12_narrow
  import fp_pkg::*;
#(
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fp16_to_fp12_narrow_if.slave        bus,
  input  logic                        cnt_clear,
  output logic [CNT_W-1:0]            cnt_inexact,
  output logic [CNT_W-1:0]            cnt_overflow,
  output logic [CNT_W-1:0]            cnt_nan
);

  logic w_en1, w_en2, w_in_hs, w_out_hs, w_rnd;
  logic w_in_exp_max, w_in_man_nz;

  logic                  r_s1_valid, r_s1_sign, r_s1_guard, r_s1_sticky;
  logic                  r_s1_nan, r_s1_inf, r_s1_rnd;
  logic [FP12_EXP_W-1:0] r_s1_exp;
  logic [FP12_MAN_W-1:0] r_s1_kept;

  logic        r_s2_valid;
  logic [11:0] r_s2_data;
  fp_flags_t   r_s2_flags;

  logic [10:0] w_mag;
  logic [11:0] w_res;
  fp_flags_t   w_flags;

  // Bubbles collapse: stage 1 may load whenever it is empty or stage 2 drains
  assign w_en2       = !r_s2_valid || bus.out_ready;
  assign w_en1       = w_en2 || !r_s1_valid;
  assign bus.in_ready = w_en1;
  assign w_in_hs     = bus.in_valid && w_en1;
  assign w_out_hs    = r_s2_valid && bus.out_ready;

  assign w_in_exp_max = (bus.in_data[14:10] == EXP_MAX);
  assign w_in_man_nz  = |bus.in_data[9:0];

`ifdef FP16_TO_FP12_STOCHASTIC_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_in_hs) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR16_TAPS) : (r_lfsr >> 1);
    end
  end

  // Round up when the dropped bits plus the random nibble carry out
  assign w_rnd = (({1'b0, bus.in_data[3:0]} + {1'b0, r_lfsr[3:0]}) > 5'd15);
`else
  assign w_rnd = bus.in_data[3] && ((|bus.in_data[2:0]) || bus.in_data[4]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_kept   <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_nan    <= 1'b0;
      r_s1_inf    <= 1'b0;
      r_s1_rnd    <= 1'b0;
    end else if (w_en1) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sign   <= bus.in_data[15];
        r_s1_exp    <= bus.in_data[14:10];
        r_s1_kept   <= bus.in_data[9:DROP_W];
        r_s1_guard  <= bus.in_data[DROP_W-1];
        r_s1_sticky <= |bus.in_data[DROP_W-2:0];
        r_s1_nan    <= w_in_exp_max && w_in_man_nz;
        r_s1_inf    <= w_in_exp_max && !w_in_man_nz;
        r_s1_rnd    <= w_rnd;
      end
    end
  end

  // Exponent and mantissa share one adder so the round carry ripples into the exponent
  assign w_mag = {r_s1_exp, r_s1_kept} + {10'd0, r_s1_rnd};

  always_comb begin
    w_res   = {r_s1_sign, w_mag};
    w_flags = '{nan: 1'b0, overflow: 1'b0, inexact: r_s1_guard || r_s1_sticky};
    if (r_s1_nan) begin
      w_res   = {r_s1_sign, FP12_QNAN[10:0]};
      w_flags = '{nan: 1'b1, overflow: 1'b0, inexact: 1'b0};
    end else if (r_s1_inf) begin
      w_res   = {r_s1_sign, EXP_MAX, 6'h00};
      w_flags = '0;
    end else if (w_mag[10:6] == EXP_MAX) begin
      w_res   = (SATURATE != 0) ? {r_s1_sign, FP12_MAX_FIN} : {r_s1_sign, EXP_MAX, 6'h00};
      w_flags = '{nan: 1'b0, overflow: 1'b1, inexact: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_flags <= '0;
    end else if (w_en2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data  <= w_res;
        r_s2_flags <= w_flags;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_flags = r_s2_flags;

  fp_sat_counter #(.CNT_W(CNT_W)) u_cnt_inexact (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_out_hs && r_s2_flags.inexact),
    .clr   (cnt_clear),
    .count (cnt_inexact)
  );

  fp_sat_counter #(.CNT_W(CNT_W)) u_cnt_overflow (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_out_hs && r_s2_flags.overflow),
    .clr   (cnt_clear),
    .count (cnt_overflow)
  );

  fp_sat_counter #(.CNT_W(CNT_W)) u_cnt_nan (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_out_hs && r_s2_flags.nan),
    .clr   (cnt_clear),
    .count (cnt_nan)
  );

endmodule

// File: tb/tb_fp16_to_fp12_narrow.sv
// Randomized and directed bench for fp16_to_fp12_narrow; two instances (SATURATE=0/1)
// share one stimulus stream and are scored against an integer-rounding reference model.
module tb_fp16_to_fp12_narrow;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tb_in_valid = 1'b0;
  logic [15:0] tb_in_data  = '0;
  logic        out_ready_man = 1'b1;
  logic        rnd_ready = 1'b1;
  logic        rand_mode = 1'b0;
  logic        tb_cnt_clear = 1'b0;

  logic [15:0] cnt_inexact, cnt_overflow, cnt_nan;
  logic [15:0] s_cnt_inexact, s_cnt_overflow, s_cnt_nan;

  fp16_to_fp12_narrow_if bus ();
  fp16_to_fp12_narrow_if bus_s ();

  assign bus.in_valid   = tb_in_valid;
  assign bus.in_data    = tb_in_data;
  assign bus.out_ready  = rand_mode ? rnd_ready : out_ready_man;
  assign bus_s.in_valid  = tb_in_valid;
  assign bus_s.in_data   = tb_in_data;
  assign bus_s.out_ready = rand_mode ? rnd_ready : out_ready_man;

  fp16_to_fp12_narrow #(.SATURATE(0), .CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cnt_clear    (tb_cnt_clear),
    .cnt_inexact  (cnt_inexact),
    .cnt_overflow (cnt_overflow),
    .cnt_nan      (cnt_nan)
  );

  fp16_to_fp12_narrow #(.SATURATE(1), .CNT_W(16), .LFSR_SEED(16'hACE1)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_s),
    .cnt_clear    (tb_cnt_clear),
    .cnt_inexact  (s_cnt_inexact),
    .cnt_overflow (s_cnt_overflow),
    .cnt_nan      (s_cnt_nan)
  );

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: round the 15-bit magnitude pattern to a multiple of 16, ties to even
  function automatic void ref_conv(input logic [15:0] x, input bit sat,
                                   output logic [11:0] d, output logic [2:0] f);
    int unsigned e, m, mag, q, rem;
    logic sgn;
    sgn = x[15];
    e   = (32'(x) >> 10) & 31;
    m   = 32'(x) & 1023;
    mag = 32'(x) & 32'h7FFF;
    if (e == 31) begin
      if (m != 0) begin d = {sgn, 11'h7E0}; f = 3'b100; end
      else        begin d = {sgn, 11'h7C0}; f = 3'b000; end
    end else begin
      q   = mag / 16;
      rem = mag % 16;
      if (rem > 8 || (rem == 8 && (q % 2) == 1)) q = q + 1;
      if (q >= 31 * 64) begin
        f = 3'b011;
        d = sat ? {sgn, 11'h7BF} : {sgn, 11'h7C0};
      end else begin
        d = {sgn, q[10:0]};
        f = {2'b00, rem != 0};
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard and counter model
  logic [15:0] q_in[$];
  logic [15:0] m_inex = 0, m_ovf = 0, m_nan = 0;
  logic        stall_prev = 0;
  logic [11:0] prev_d, prev_ds;
  logic [2:0]  prev_f;

  always @(negedge clk) begin
    logic [11:0] ed, eds;
    logic [2:0]  ef, efs;
    logic [15:0] w;
    bit          hs;
    if (!rst_n) begin
      q_in.delete();
      m_inex = 0; m_ovf = 0; m_nan = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold", {bus.out_valid, bus.out_flags, bus.out_data, bus_s.out_data},
            {1'b1, prev_f, prev_d, prev_ds});
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data; prev_ds = bus_s.out_data; prev_f = bus.out_flags;
      chk("valid_pair", {bus_s.out_valid, bus_s.in_ready}, {bus.out_valid, bus.in_ready});

      chk("counters", {cnt_inexact, cnt_overflow, cnt_nan}, {m_inex, m_ovf, m_nan});
      chk("counters_sat", {s_cnt_inexact, s_cnt_overflow, s_cnt_nan}, {m_inex, m_ovf, m_nan});

      hs = bus.out_valid && bus.out_ready;
      ef = 3'b000;
      if (hs) begin
        n_out++;
        if (q_in.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          w = q_in.pop_front();
          ref_conv(w, 1'b0, ed, ef);
          ref_conv(w, 1'b1, eds, efs);
          chk("out_data", 32'(bus.out_data), 32'(ed));
          chk("out_flags", 32'(bus.out_flags), 32'(ef));
          chk("sat_out", {bus_s.out_flags, bus_s.out_data}, {efs, eds});
        end
      end
      if (tb_cnt_clear) begin
        m_inex = 0; m_ovf = 0; m_nan = 0;
      end else if (hs) begin
        if (ef[0] && m_inex != 16'hFFFF) m_inex++;
        if (ef[1] && m_ovf  != 16'hFFFF) m_ovf++;
        if (ef[2] && m_nan  != 16'hFFFF) m_nan++;
      end
      if (bus.in_valid && bus.in_ready) q_in.push_back(bus.in_data);
    end
  end

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    tb_in_valid = 1'b1;
    tb_in_data  = w;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    tb_in_valid = 1'b0;
    while ((q_in.size() != 0 || bus.out_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("drain_timeout", 32'(q_in.size()), 32'd0);
  endtask

  task automatic directed(input logic [15:0] w, input logic [11:0] ed, input logic [2:0] ef,
                          input logic [11:0] eds);
    logic [11:0] md;
    logic [2:0]  mf;
    int lat;
    ref_conv(w, 1'b0, md, mf);
    chk("model_pin", {md, mf}, {ed, ef});
    ref_conv(w, 1'b1, md, mf);
    chk("model_pin_sat", {md, mf}, {eds, ef});
    send(w);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'd2);
    chk("lit_data", {w, 4'h0, bus.out_data}, {w, 4'h0, ed});
    chk("lit_flags", {w, 13'h0, bus.out_flags}, {w, 13'h0, ef});
    chk("lit_sat", {w, 4'h0, bus_s.out_data}, {w, 4'h0, eds});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r[14:10] = 5'h1F;
      1: r[14:10] = 5'h1E;
      2: r[14:10] = 5'h00;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [15:0] words[4];
    int idx, base;
    logic [11:0] hold_d;

    #2;
    @(negedge clk);
    chk("rst_state", {bus.out_valid, bus.in_ready, bus.out_data, bus.out_flags},
        {1'b0, 1'b1, 12'h000, 3'b000});
    chk("rst_cnt", {cnt_inexact, cnt_overflow, cnt_nan}, 48'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    directed(16'h3C00, 12'h3C0, 3'b000, 12'h3C0);
    directed(16'h3C08, 12'h3C0, 3'b001, 12'h3C0);
    directed(16'h3C18, 12'h3C2, 3'b001, 12'h3C2);
    directed(16'h3C09, 12'h3C1, 3'b001, 12'h3C1);
    directed(16'h0008, 12'h000, 3'b001, 12'h000);
    directed(16'h03F8, 12'h040, 3'b001, 12'h040);
    directed(16'h8000, 12'h800, 3'b000, 12'h800);
    directed(16'h7BFF, 12'h7C0, 3'b011, 12'h7BF);
    directed(16'hFBF0, 12'hFBF, 3'b000, 12'hFBF);
    directed(16'h7E01, 12'h7E0, 3'b100, 12'h7E0);
    directed(16'hFC00, 12'hFC0, 3'b000, 12'hFC0);
    directed(16'h7C01, 12'h7E0, 3'b100, 12'h7E0);
    directed(16'hFBFF, 12'hFC0, 3'b011, 12'hFBF);

    // Backpressure: 4 words offered against a 6-cycle stall
    words = '{16'h3C08, 16'h3C18, 16'h4000, 16'hC123};
    drain();
    base = n_out;
    out_ready_man = 1'b0;
    idx = 0;
    hold_d = 12'h000;
    for (int c = 0; c < 6; c++) begin
      bit hs;
      tb_in_valid = (idx < 4);
      tb_in_data  = words[idx % 4];
      @(negedge clk);
      hs = tb_in_valid && bus.in_ready;
      if (c == 2) hold_d = bus.out_data;
      if (c > 2) chk("bp_hold", 32'(bus.out_data), 32'(hold_d));
      @(posedge clk);
      #1;
      if (hs) idx++;
    end
    @(negedge clk);
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", {bus.in_ready, bus.out_valid, bus.out_data}, {1'b0, 1'b1, 12'h3C0});
    @(posedge clk);
    #1;
    out_ready_man = 1'b1;
    while (idx < 4) begin
      send(words[idx]);
      idx++;
    end
    drain();
    chk("bp_delivered", 32'(n_out - base), 32'd4);

    // Randomized stream with random downstream stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tb_in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rand_word());
    end
    rand_mode = 1'b0;
    out_ready_man = 1'b1;
    drain();

    // Reset while the pipeline is stalled and full
    out_ready_man = 1'b0;
    tb_in_valid = 1'b1;
    tb_in_data  = 16'h7E01;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", {bus.out_valid, bus.in_ready, cnt_inexact, cnt_overflow, cnt_nan},
        {1'b0, 1'b1, 48'h0});
    @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready_man = 1'b1;

    // Clear coincident with an inexact delivery, then saturate the inexact counter
    tb_in_valid = 1'b1;
    tb_in_data  = 16'h3C08;
    repeat (5) @(posedge clk);
    #1;
    tb_cnt_clear = 1'b1;
    @(negedge clk);
    chk("clr_hs", {bus.out_valid, bus.out_ready, bus.out_flags}, {1'b1, 1'b1, 3'b001});
    @(posedge clk);
    #1;
    tb_cnt_clear = 1'b0;
    @(negedge clk);
    chk("clr_prio", 32'(cnt_inexact), 32'd0);
    repeat (70000) @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
    @(negedge clk);
    chk("cnt_sat", {cnt_inexact, cnt_overflow, cnt_nan}, {16'hFFFF, 16'h0, 16'h0});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp16_to_fp12_narrow.md
Name: fp16_to_fp12_narrow

Overview:
Streaming narrowing converter from FP16 (E5M10, bias 15) to FP12 (E5M6, bias 15) for the arithmetic path.
- It is the return direction of the FP12 reciprocal unit: FP16 results (reciprocals, quotients) are requantized to FP12 for storage and operand buses.
- Two-stage valid/ready pipeline with round-to-nearest-even and per-result exception flags.
- Saturating event counters for software visibility.

Parameters:
SATURATE, 0, 1: finite inputs that round past max finite produce ±max finite (0x7BF/0xFBF) instead of ±Inf.
CNT_W, 16, width of each event counter.
LFSR_SEED, 16'hACE1, reset value of the stochastic-rounding LFSR (used only with the optional feature).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept a word this cycle
in_data  in  16  FP16 operand
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  12  FP12 result
out_flags  out  3  {nan, overflow, inexact}, aligned with out_data
cnt_clear  in  1  synchronous clear of all counters
cnt_inexact  out  CNT_W  count of delivered inexact results
cnt_overflow  out  CNT_W  count of delivered overflow results
cnt_nan  out  CNT_W  count of delivered NaN results

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0 except in_ready=1. Pipeline valids are cleared; counters are 0; LFSR=LFSR_SEED.
- A reset mid-stream drops in-flight words.

Handshake:
- Transfer occurs when valid&&ready.
- Stage-2 enable: en2 = !s2_valid || out_ready.
- Stage-1 enable: en1 = en2 || !s1_valid.
- in_ready = en1. Bubbles collapse, so throughput is 1 word/cycle.
- Latency: 2 cycles from input acceptance to out_valid, when not stalled.
- Stalled data and flags hold stable. Order is preserved; no word is lost or duplicated.

Stage 1 (registered decode):
- Register sign, exponent, kept mantissa k=in[9:4], guard g=in[3], sticky s=|in[2:0], class (NaN: exp=31 and mant≠0; Inf: exp=31 and mant=0).
- Compute rnd = g&&(s||k[0]) (RNE).

Stage 2 (registered result):
- Sum r = {exp,k} + rnd as an 11-bit magnitude. Carry propagates naturally: subnormal→normal, and mantissa overflow into the exponent.
- NaN → {sign,5'h1F,6'b100000}, flags nan=1, inexact=0.
- Inf → {sign,5'h1F,6'h00}, no flags.
- Finite with r[10:6]=31 → overflow=1, inexact=1. Output is ±Inf, or ±max finite when SATURATE=1.
- Otherwise out = {sign,r}; inexact = g||s.
- Zero and signed zero pass through exactly.

Counters:
- Each counter increments by 1 on the output handshake when its flag is set, and saturates at all-ones.
- cnt_clear has priority over a same-cycle increment (result 0).

Optional Feature:
Macro FP16_TO_FP12_STOCHASTIC_EN.
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11) advances on each input handshake.
  - rnd is replaced by carry-out of in[3:0] + lfsr[3:0].
  - inexact remains (in[3:0]≠0).
  - The NaN/Inf/overflow rules are unchanged.
- Undefined: RNE only; no LFSR logic exists.

Decomposition:
Shared package fp_pkg holds:
- FP16 and FP12 field widths, the bias, EXP_MAX=5'h1F.
- FP12 canonical NaN 12'h7E0 and max finite 11'h7BF.
- A flags struct/typedef {nan, overflow, inexact}.

Sub-module fp_sat_counter (CNT_W, inc, clr) is instanced three times. All other logic stays in the top module.

Test Plan:
- Rounding: 0x3C00→0x3C0 flags 0; 0x3C08→0x3C0 inexact; 0x3C18→0x3C2 inexact; 0x3C09→0x3C1 inexact.
- Subnormal: 0x0008→0x000 inexact; 0x03F8→0x040 (carries to exp 1) inexact; 0x8000→0x800 flags 0.
- Overflow: 0x7BFF→0x7C0 {overflow,inexact} with SATURATE=0; →0x7BF with SATURATE=1; 0xFBF0→0xFBF exact.
- Specials: 0x7E01→0x7E0 nan; 0xFC00→0xFC0 flags 0; 0x7C01 must not output Inf.
- Backpressure: out_ready=0 for 6 cycles while driving 4 words with in_valid=1 → in_ready drops after 2 accepted. Release → 4 results in order, out_data stable during the stall.
- Counters: 70000 inexact handshakes → cnt_inexact=0xFFFF. cnt_clear asserted coincident with an inexact handshake → 0. Reset mid-stall → out_valid=0 next cycle, counters 0.
